// File: rtl/instr_ram_pkg.sv
// Shared defaults and types for the instruction RAM arbiter.
package instr_ram_pkg;
    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;
    localparam int STARVE_CNT_W   = 8;

    typedef enum logic [1:0] {
        GRANT_NONE   = 2'd0,
        GRANT_FETCH  = 2'd1,
        GRANT_LOADER = 2'd2
    } grant_e;
endpackage

// File: rtl/instr_ram_arbiter_if.sv
// Fetch port, loader port and RAM-side signals of the instruction RAM arbiter.
interface instr_ram_arbiter_if import instr_ram_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // A transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits for ready, and a held response keeps its data stable.
    logic                    f_req_valid;
    logic [ADDR_W-1:0]       f_req_addr;
    logic                    f_req_ready;
    logic                    f_rsp_valid;
    logic [DATA_W-1:0]       f_rsp_rdata;
    logic                    f_rsp_ready;
    logic                    l_req_valid;
    logic                    l_req_we;
    logic [ADDR_W-1:0]       l_req_addr;
    logic [DATA_W-1:0]       l_req_wdata;
    logic                    l_req_ready;
    logic                    l_rsp_valid;
    logic [DATA_W-1:0]       l_rsp_rdata;
    logic                    l_rsp_ready;
    logic                    ram_we;
    logic [ADDR_W-1:0]       ram_address;
    logic [DATA_W-1:0]       ram_wdata;
    logic [DATA_W-1:0]       ram_rdata;
    logic [STARVE_CNT_W-1:0] starve_cnt;

    modport slave (
        input  f_req_valid, f_req_addr, f_rsp_ready,
        input  l_req_valid, l_req_we, l_req_addr, l_req_wdata, l_rsp_ready,
        input  ram_rdata,
        output f_req_ready, f_rsp_valid, f_rsp_rdata,
        output l_req_ready, l_rsp_valid, l_rsp_rdata,
        output ram_we, ram_address, ram_wdata, starve_cnt
    );

    modport master (
        output f_req_valid, f_req_addr, f_rsp_ready,
        output l_req_valid, l_req_we, l_req_addr, l_req_wdata, l_rsp_ready,
        output ram_rdata,
        input  f_req_ready, f_rsp_valid, f_rsp_rdata,
        input  l_req_ready, l_rsp_valid, l_rsp_rdata,
        input  ram_we, ram_address, ram_wdata, starve_cnt
    );
endinterface

// File: rtl/instr_ram_arbiter_rsp_slot.sv
// One-entry response register: load wins over consume so a same-cycle
// consume and new grant refills the slot without a bubble.
module rsp_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              rsp_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/instr_ram_arbiter.sv
// Arbitrates fetch and loader access to a single-port instruction RAM,
// loader first, with a starvation limit that forces a fetch grant.
module instr_ram_arbiter import instr_ram_pkg::*; #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input logic                clk,
    input logic                rst_n,
    instr_ram_arbiter_if.slave bus
);
    localparam logic [STARVE_CNT_W-1:0] STARVE_LIMIT = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    f_eligible;
    logic                    l_eligible;
    grant_e                  grant;
    logic [ADDR_W-1:0]       addr_sel;
    logic [DATA_W-1:0]       wdata_sel;
    logic [DATA_W-1:0]       l_load_data;
    logic                    f_rsp_valid;
    logic                    l_rsp_valid;
    logic [DATA_W-1:0]       f_rsp_rdata;
    logic [DATA_W-1:0]       l_rsp_rdata;

    // Gating with rst_n keeps ready and ram_we low for the whole reset window.
    always_comb begin
        f_eligible = rst_n && bus.f_req_valid && (!f_rsp_valid || bus.f_rsp_ready);
        l_eligible = rst_n && bus.l_req_valid && (!l_rsp_valid || bus.l_rsp_ready);
        grant      = GRANT_NONE;
        if (l_eligible && !(f_eligible && starve_cnt == STARVE_LIMIT)) begin
            grant = GRANT_LOADER;
        end else if (f_eligible) begin
            grant = GRANT_FETCH;
        end
    end

    always_comb begin
        addr_sel    = bus.f_req_addr;
        wdata_sel   = '0;
        if (grant == GRANT_LOADER) begin
            addr_sel  = bus.l_req_addr;
            wdata_sel = bus.l_req_wdata;
        end
        l_load_data = bus.l_req_we ? '0 : bus.ram_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!bus.f_req_valid || grant == GRANT_FETCH) begin
            starve_cnt <= '0;
        end else if (grant == GRANT_LOADER && f_eligible && starve_cnt != STARVE_LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    rsp_slot #(.DATA_W(DATA_W)) u_f_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (grant == GRANT_FETCH),
        .load_data (bus.ram_rdata),
        .rsp_ready (bus.f_rsp_ready),
        .rsp_valid (f_rsp_valid),
        .rsp_rdata (f_rsp_rdata)
    );

    rsp_slot #(.DATA_W(DATA_W)) u_l_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (grant == GRANT_LOADER),
        .load_data (l_load_data),
        .rsp_ready (bus.l_rsp_ready),
        .rsp_valid (l_rsp_valid),
        .rsp_rdata (l_rsp_rdata)
    );

    assign bus.f_req_ready = (grant == GRANT_FETCH);
    assign bus.l_req_ready = (grant == GRANT_LOADER);
    assign bus.f_rsp_valid = f_rsp_valid;
    assign bus.f_rsp_rdata = f_rsp_rdata;
    assign bus.l_rsp_valid = l_rsp_valid;
    assign bus.l_rsp_rdata = l_rsp_rdata;
    assign bus.ram_we      = (grant == GRANT_LOADER) && bus.l_req_we;
    assign bus.ram_address = addr_sel;
    assign bus.ram_wdata   = wdata_sel;
    assign bus.starve_cnt  = starve_cnt;
endmodule
